// File: rtl/instruction_memory_if.sv
// ----------------------------------------------------------------------------
// instruction_memory_if
//
// Purpose:
//   Groups the two buses of the instruction memory into one interface:
//     - the fetch-side read bus (byte address in, instruction word out), and
//     - the boot-loader byte stream (start/length plus valid/ready bytes).
//
// Modports:
//   master : driven by the fetch stage and the program loader
//            (inst_addr, load_start, load_words, load_data, load_valid out;
//             inst_data, addr_fault, load_ready, load_busy, load_err in)
//   slave  : the instruction memory itself (the mirror image of master)
//
// Parameters:
//   DEPTH_WORDS : number of 32-bit words in the memory; sets the width of
//                 load_words so that a load of exactly DEPTH_WORDS fits.
// ----------------------------------------------------------------------------
interface instruction_memory_if #(
    parameter int DEPTH_WORDS = 1024
);
    localparam int LW = $clog2(DEPTH_WORDS) + 1;

    // Fetch read bus
    logic [31:0]   inst_addr;
    logic [31:0]   inst_data;
    logic          addr_fault;

    // Boot-loader byte stream
    logic          load_start;
    logic [LW-1:0] load_words;
    logic [7:0]    load_data;
    logic          load_valid;
    logic          load_ready;
    logic          load_busy;
    logic          load_err;

    modport master (
        output inst_addr,
        output load_start,
        output load_words,
        output load_data,
        output load_valid,
        input  inst_data,
        input  addr_fault,
        input  load_ready,
        input  load_busy,
        input  load_err
    );

    modport slave (
        input  inst_addr,
        input  load_start,
        input  load_words,
        input  load_data,
        input  load_valid,
        output inst_data,
        output addr_fault,
        output load_ready,
        output load_busy,
        output load_err
    );
endinterface

// File: rtl/instruction_memory.sv
// ----------------------------------------------------------------------------
// instruction_memory
//
// Purpose:
//   Word-organised instruction memory for the fetch stage. Fetch presents a
//   byte address and receives the instruction word combinationally in the
//   same cycle. A small boot-loader FSM fills the array from a little-endian
//   byte stream and holds the core stalled (core_clk_en low) until the
//   requested number of words has been written.
//
// Ports:
//   clk         : clock
//   rst_n       : asynchronous reset, active low (array contents survive it)
//   bus         : instruction_memory_if.slave
//                   inst_addr/inst_data/addr_fault  - fetch read bus
//                   load_start/load_words           - begin a load of N words
//                   load_data/load_valid/load_ready - byte stream handshake
//                   load_busy                       - FSM is loading
//                   load_err                        - sticky: oversize load
//   core_clk_en : clock enable for the core pipeline, high only in RUN
//
// Parameters:
//   DEPTH_WORDS : number of 32-bit words (power of two, >= 4)
//   NOP_WORD    : word returned whenever a fetch is not served
// ----------------------------------------------------------------------------
module instruction_memory #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] NOP_WORD    = 32'h0000_0013
) (
    input  logic                  clk,
    input  logic                  rst_n,
    instruction_memory_if.slave   bus,
    output logic                  core_clk_en
);

    localparam int            AW       = $clog2(DEPTH_WORDS);
    localparam int            LW       = AW + 1;
    localparam logic [LW-1:0] DEPTH_LW = LW'(DEPTH_WORDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t        state;
    logic [1:0]    byte_cnt;
    logic [LW-1:0] word_cnt;
    logic [LW-1:0] word_len;
    // Only the lower three bytes are held; the fourth byte goes straight
    // into the array together with these on the completing edge.
    logic [23:0]   asm_reg;
    logic          load_ready_q;
    logic          load_busy_q;
    logic          load_err_q;

    logic [31:0]   mem [DEPTH_WORDS];

    logic          byte_fire;
    logic          word_done;
    logic [31:0]   full_word;
    logic          addr_ok;

    // load_ready is high exactly while in LOAD, so the handshake reduces to
    // the state test plus load_valid.
    assign byte_fire = (state == LOAD) && bus.load_valid;
    assign word_done = byte_fire && (byte_cnt == 2'd3);
    assign full_word = {bus.load_data, asm_reg};

    assign bus.load_ready = load_ready_q;
    assign bus.load_busy  = load_busy_q;
    assign bus.load_err   = load_err_q;

    // Boot-loader FSM with registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            byte_cnt     <= 2'd0;
            word_cnt     <= '0;
            word_len     <= '0;
            asm_reg      <= '0;
            load_ready_q <= 1'b0;
            load_busy_q  <= 1'b0;
            load_err_q   <= 1'b0;
            core_clk_en  <= 1'b0;
        end else begin
            case (state)
                IDLE, RUN: begin
                    if (bus.load_start) begin
                        word_len <= bus.load_words;
                        byte_cnt <= 2'd0;
                        word_cnt <= '0;
                        asm_reg  <= '0;
                        if (bus.load_words == '0) begin
                            state        <= RUN;
                            core_clk_en  <= 1'b1;
                            load_ready_q <= 1'b0;
                            load_busy_q  <= 1'b0;
                            load_err_q   <= 1'b0;
                        end else if (bus.load_words > DEPTH_LW) begin
                            // Oversize request: refuse it and park in IDLE
                            // with the core stalled.
                            state        <= IDLE;
                            core_clk_en  <= 1'b0;
                            load_ready_q <= 1'b0;
                            load_busy_q  <= 1'b0;
                            load_err_q   <= 1'b1;
                        end else begin
                            state        <= LOAD;
                            core_clk_en  <= 1'b0;
                            load_ready_q <= 1'b1;
                            load_busy_q  <= 1'b1;
                            load_err_q   <= 1'b0;
                        end
                    end
                end

                LOAD: begin
                    // load_start is deliberately ignored here.
                    if (byte_fire) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        case (byte_cnt)
                            2'd0: asm_reg[7:0]   <= bus.load_data;
                            2'd1: asm_reg[15:8]  <= bus.load_data;
                            2'd2: asm_reg[23:16] <= bus.load_data;
                            default: begin
                                word_cnt <= word_cnt + LW'(1);
                                asm_reg  <= '0;
                                if ((word_cnt + LW'(1)) == word_len) begin
                                    state        <= RUN;
                                    core_clk_en  <= 1'b1;
                                    load_ready_q <= 1'b0;
                                    load_busy_q  <= 1'b0;
                                end
                            end
                        endcase
                    end
                end

                default: begin
                    state        <= IDLE;
                    core_clk_en  <= 1'b0;
                    load_ready_q <= 1'b0;
                    load_busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Array write port. No reset: program contents survive rst_n. While
    // rst_n is low the FSM sits in IDLE, so no write can slip through.
    always_ff @(posedge clk) begin
        if (word_done) begin
            mem[word_cnt[AW-1:0]] <= full_word;
        end
    end

    // Zero-latency read path. Outside RUN the fetch stage is stalled, so it
    // simply sees NOP_WORD and no fault.
    assign addr_ok = (bus.inst_addr[1:0] == 2'b00) &&
                     (bus.inst_addr[31:2] < 30'(DEPTH_WORDS));

    always_comb begin
        bus.inst_data  = NOP_WORD;
        bus.addr_fault = 1'b0;
        if (state == RUN) begin
            if (addr_ok) begin
                bus.inst_data = mem[bus.inst_addr[AW+1:2]];
            end else begin
                bus.addr_fault = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instruction_memory.sv
// ----------------------------------------------------------------------------
// tb_instruction_memory
//
// Purpose:
//   Self-checking bench for instruction_memory. Directed loads cover the
//   documented scenarios; randomized loads (random length, random bytes,
//   random valid gaps, spurious load_start while loading) and random reads
//   follow. Expected outputs come from a behavioural model that tracks the
//   program as a list of words assembled from the byte stream, and are
//   queued for a separate negedge monitor that compares them.
// ----------------------------------------------------------------------------
module tb_instruction_memory;

    localparam int          DEPTH = 16;
    localparam int          LW    = $clog2(DEPTH) + 1;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst_n;
    logic core_clk_en;

    instruction_memory_if #(.DEPTH_WORDS(DEPTH)) bus ();

    instruction_memory #(
        .DEPTH_WORDS (DEPTH),
        .NOP_WORD    (NOP)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .core_clk_en (core_clk_en)
    );

    always #5 clk = ~clk;

    // Scoreboard entry: either a full output snapshot or a scalar count.
    typedef struct {
        string       name;
        bit          scalar;
        int          got;
        int          req;
        logic [31:0] data;
        logic        fault;
        logic        clk_en;
        logic        busy;
        logic        ready;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks     = 0;
    int   n_fail       = 0;
    int   ready_cycles = 0;

    // Behavioural model: program words, run/load/error status, and the
    // bytes received so far for the word being assembled.
    logic [31:0] m_mem [DEPTH];
    bit          m_run;
    bit          m_busy;
    bit          m_err;
    int          m_len;
    int          m_done;
    logic [7:0]  m_part[$];

    function automatic void model_reset();
        m_run  = 1'b0;
        m_busy = 1'b0;
        m_err  = 1'b0;
        m_part.delete();
    endfunction

    function automatic void model_start(input int n);
        if (m_busy) return;
        if (n == 0) begin
            m_run = 1'b1; m_busy = 1'b0; m_err = 1'b0;
        end else if (n > DEPTH) begin
            m_run = 1'b0; m_busy = 1'b0; m_err = 1'b1;
        end else begin
            m_run = 1'b0; m_busy = 1'b1; m_err = 1'b0;
            m_len = n; m_done = 0;
            m_part.delete();
        end
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        m_part.push_back(b);
        if (m_part.size() == 4) begin
            m_mem[m_done] = {m_part[3], m_part[2], m_part[1], m_part[0]};
            m_part.delete();
            m_done++;
            if (m_done == m_len) begin
                m_busy = 1'b0;
                m_run  = 1'b1;
            end
        end
    endfunction

    // Queue the expected outputs for the current cycle and current address.
    function automatic void check_output(input string name);
        exp_t        e;
        logic [31:0] a = bus.inst_addr;
        e.name   = name;
        e.scalar = 1'b0;
        e.got    = 0;
        e.req    = 0;
        e.data   = NOP;
        e.fault  = 1'b0;
        if (m_run) begin
            if ((a % 4 == 0) && ((a >> 2) < 32'(DEPTH))) e.data = m_mem[int'(a >> 2)];
            else e.fault = 1'b1;
        end
        e.clk_en = m_run;
        e.busy   = m_busy;
        e.ready  = m_busy;
        e.err    = m_err;
        exp_q.push_back(e);
    endfunction

    function automatic void check_count(input string name, input int got, input int req);
        exp_t e;
        e.name   = name;
        e.scalar = 1'b1;
        e.got    = got;
        e.req    = req;
        e.data   = '0;
        e.fault  = 1'b0;
        e.clk_en = 1'b0;
        e.busy   = 1'b0;
        e.ready  = 1'b0;
        e.err    = 1'b0;
        exp_q.push_back(e);
    endfunction

    // Monitor: compare every queued expectation at the falling edge.
    always @(negedge clk) begin
        if (bus.load_ready === 1'b1) ready_cycles++;
        while (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            n_checks++;
            if (mon_e.scalar) begin
                if (mon_e.got != mon_e.req) begin
                    n_fail++;
                    $display("[TB] FAIL %s: actual %0d, required %0d", mon_e.name, mon_e.got, mon_e.req);
                end
            end else if ({bus.inst_data, bus.addr_fault, core_clk_en, bus.load_busy, bus.load_ready, bus.load_err} !==
                         {mon_e.data, mon_e.fault, mon_e.clk_en, mon_e.busy, mon_e.ready, mon_e.err}) begin
                n_fail++;
                $display("[TB] FAIL %s @%0t: actual data=%h fault=%b clk_en=%b busy=%b ready=%b err=%b, required data=%h fault=%b clk_en=%b busy=%b ready=%b err=%b",
                         mon_e.name, $time, bus.inst_data, bus.addr_fault, core_clk_en, bus.load_busy,
                         bus.load_ready, bus.load_err, mon_e.data, mon_e.fault, mon_e.clk_en,
                         mon_e.busy, mon_e.ready, mon_e.err);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue load_start with n words, then stream bytes.
    // mode 0: valid always high; 1: valid low/high alternating starting low;
    // 2: random valid plus occasional spurious load_start during the load.
    task automatic apply_stimulus(input int n, input logic [7:0] bytes[$],
                                  input int mode, input int stop_after);
        int idx = 0;
        int cyc = 0;
        logic v;
        bus.load_start = 1'b1;
        bus.load_words = LW'(n);
        bus.load_valid = 1'b0;
        check_output("start_cycle");
        @(posedge clk);
        model_start(n);
        #1;
        bus.load_start = 1'b0;
        while (m_busy && idx < stop_after && cyc < 4000) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 1);
                default: v = 1'($urandom_range(0, 1));
            endcase
            bus.load_valid = v;
            bus.load_data  = bytes[idx];
            if (mode == 2 && $urandom_range(0, 7) == 0) begin
                bus.load_start = 1'b1;
                bus.load_words = LW'($urandom_range(0, (1 << LW) - 1));
            end
            check_output("load_cycle");
            @(posedge clk);
            if (v && m_busy) begin
                model_byte(bytes[idx]);
                idx++;
            end
            #1;
            bus.load_start = 1'b0;
            bus.load_valid = 1'b0;
            cyc++;
        end
        if (cyc >= 4000) check_count("load_timeout", cyc, 0);
        check_output("load_end");
        tick();
    endtask

    task automatic read_at(input logic [31:0] a, input string name);
        bus.inst_addr = a;
        check_output(name);
        tick();
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        model_reset();
        check_output("reset_async");
        tick();
        check_output("reset_hold");
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        logic [7:0]  prog[$];
        logic [7:0]  bq[$];
        logic [31:0] a;
        int          snap;
        int          n;

        rst_n          = 1'b1;
        bus.inst_addr  = '0;
        bus.load_start = 1'b0;
        bus.load_words = '0;
        bus.load_data  = '0;
        bus.load_valid = 1'b0;
        model_reset();
        #2 rst_n = 1'b0;
        tick();
        check_output("reset_state");
        tick();
        rst_n = 1'b1;
        tick();
        check_output("idle_after_reset");

        // Fill every word (load of exactly DEPTH words).
        bq.delete();
        for (int i = 0; i < 4 * DEPTH; i++) bq.push_back(8'($urandom()));
        apply_stimulus(DEPTH, bq, 0, 4 * DEPTH);
        read_at(32'(4 * (DEPTH - 1)), "full_last_word");

        // Two-word program, valid always high.
        prog = '{8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h08, 8'h20, 8'h00};
        snap = ready_cycles;
        apply_stimulus(2, prog, 0, 8);
        check_count("ready_cycles_stream", ready_cycles - snap, 8);
        read_at(32'd0, "prog_word0");
        read_at(32'd4, "prog_word1");

        // Same program with valid toggling.
        snap = ready_cycles;
        apply_stimulus(2, prog, 1, 8);
        check_count("ready_cycles_toggle", ready_cycles - snap, 16);
        read_at(32'd0, "toggle_word0");
        read_at(32'd4, "toggle_word1");

        // Address boundaries.
        read_at(32'd2, "misaligned");
        read_at(32'(4 * DEPTH), "out_of_range");
        read_at(32'(4 * (DEPTH - 1)), "last_in_range");

        // Oversize request, sticky error, then zero-length load.
        bq.delete();
        apply_stimulus(DEPTH + 1, bq, 0, 0);
        read_at(32'd0, "err_idle_read");
        apply_stimulus(0, bq, 0, 0);
        read_at(32'd0, "zero_len_run");

        // Error is also cleared by reset.
        apply_stimulus(DEPTH + 1, bq, 0, 0);
        reset_pulse();

        // Reset after 6 bytes of a 2-word load.
        prog = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        apply_stimulus(2, prog, 0, 6);
        reset_pulse();
        apply_stimulus(0, bq, 0, 0);
        read_at(32'd0, "aborted_word0");
        prog = '{8'h01, 8'h02, 8'h03, 8'h04};
        apply_stimulus(1, prog, 0, 4);
        read_at(32'd0, "reload_word0");

        // Re-program from RUN.
        prog = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        apply_stimulus(1, prog, 0, 4);
        read_at(32'd0, "run_reload_word0");

        // Randomized loads and reads.
        for (int it = 0; it < 24; it++) begin
            case ($urandom_range(0, 9))
                0:       n = 0;
                1:       n = $urandom_range(DEPTH + 1, (1 << LW) - 1);
                default: n = $urandom_range(1, DEPTH);
            endcase
            bq.delete();
            for (int i = 0; i < 4 * n && n <= DEPTH; i++) bq.push_back(8'($urandom()));
            apply_stimulus(n, bq, $urandom_range(0, 2), 4 * DEPTH);
            for (int r = 0; r < 6; r++) begin
                case ($urandom_range(0, 2))
                    0:       a = 32'($urandom_range(0, DEPTH - 1)) << 2;
                    1:       a = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
                    default: a = $urandom() | 32'(4 * DEPTH);
                endcase
                read_at(a, "random_read");
            end
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: actual still running, required finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
